// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage ALU with a valid/ready handshake.
// Single-cycle ops register their result on the accept edge.
// Multiply uses shift-add and divide/remainder uses restoring division.
// Both iterative ops produce one bit per cycle over WIDTH cycles.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             v,
    output logic             dz
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_PASS = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_HAM  = 4'b1111;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_n;

    // Iteration registers: acc is product / partial remainder,
    // opa is multiplicand / dividend-then-quotient, opb is multiplier / divisor.
    logic [WIDTH-1:0] acc, opa, opb;
    logic [3:0]       opc;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] acc_n, opa_n, opb_n, md_res;
    logic [WIDTH:0]   sh, trial;

    logic [WIDTH-1:0] sc_s;
    logic             sc_v, sc_dz;
    logic [WIDTH-1:0] b_eff, sum;
    logic signed [WIDTH-1:0] a_s;
    logic [SHW-1:0]   shamt;
    logic             is_md, b_zero, go_busy, accept, last_iter;

    function automatic logic [WIDTH-1:0] popcount(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {{(WIDTH-1){1'b0}}, x[i]};
        end
        return n;
    endfunction

    assign a_s       = a;
    assign shamt     = b[SHW-1:0];
    assign b_zero    = (b == '0);
    assign is_md     = MD_EN && ((aluc == OP_MUL) || (aluc == OP_DIVU) || (aluc == OP_REMU));
    // Divide/remainder by zero resolves immediately and never enters BUSY.
    assign go_busy   = is_md && ((aluc == OP_MUL) || !b_zero);
    assign accept    = in_valid && (state == IDLE);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Single-cycle result, overflow and divide-by-zero from the live inputs.
    always_comb begin
        b_eff = (aluc == OP_SUB) ? (~b + WIDTH'(1)) : b;
        sum   = a + b_eff;
        sc_s  = '0;
        sc_v  = 1'b0;
        sc_dz = 1'b0;
        case (aluc)
            OP_ADD, OP_SUB: begin
                sc_s = sum;
                sc_v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_s = a & b;
            OP_OR:   sc_s = a | b;
            OP_XOR:  sc_s = a ^ b;
            OP_PASS: sc_s = b;
            OP_SLL:  sc_s = a << shamt;
            OP_SRL:  sc_s = a >> shamt;
            OP_SRA:  sc_s = a_s >>> shamt;
            OP_HAM:  sc_s = popcount(a ^ b);
            OP_DIVU: begin
                if (MD_EN && b_zero) begin
                    sc_s  = '1;
                    sc_dz = 1'b1;
                end
            end
            OP_REMU: begin
                if (MD_EN && b_zero) begin
                    sc_s  = a;
                    sc_dz = 1'b1;
                end
            end
            default: sc_s = '0;
        endcase
    end

    // One shift-add or restoring-division step on the iteration registers.
    always_comb begin
        acc_n = acc;
        opa_n = opa;
        opb_n = opb;
        sh    = {acc, opa[WIDTH-1]};
        trial = sh - {1'b0, opb};
        if (opc == OP_MUL) begin
            acc_n = acc + (opb[0] ? opa : '0);
            opa_n = opa << 1;
            opb_n = opb >> 1;
        end else if (!trial[WIDTH]) begin
            acc_n = trial[WIDTH-1:0];
            opa_n = {opa[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = sh[WIDTH-1:0];
            opa_n = {opa[WIDTH-2:0], 1'b0};
        end
        case (opc)
            OP_MUL:  md_res = acc_n;
            OP_DIVU: md_res = opa_n;
            default: md_res = acc_n;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!clrn) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = go_busy ? BUSY : DONE;
            BUSY:    if (last_iter) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand capture, iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            acc <= '0;
            opa <= '0;
            opb <= '0;
            opc <= '0;
            cnt <= '0;
            s   <= '0;
            z   <= 1'b0;
            v   <= 1'b0;
            dz  <= 1'b0;
        end else if (state == IDLE) begin
            if (accept && go_busy) begin
                acc <= '0;
                opa <= a;
                opb <= b;
                opc <= aluc;
                cnt <= '0;
            end else if (accept) begin
                s  <= sc_s;
                z  <= (sc_s == '0);
                v  <= sc_v;
                dz <= sc_dz;
            end
        end else if (state == BUSY) begin
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            cnt <= cnt + CW'(1);
            if (last_iter) begin
                s  <= md_res;
                z  <= (md_res == '0);
                v  <= 1'b0;
                dz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: directed cases plus random ops against a reference model.
module tb_alu_mc;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn, in_valid, in_ready, out_valid, out_ready, z, v, dz;
    logic [31:0] a, b, s;
    logic [3:0]  aluc;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, z8, v8, dz8;
    logic [7:0]  a8, b8, s8;
    logic [3:0]  aluc8;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(32), .MD_EN(1'b1)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .aluc(aluc), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .z(z), .v(v), .dz(dz)
    );

    alu_mc #(.WIDTH(8), .MD_EN(1'b1)) dut8 (
        .clk(clk), .clrn(clrn), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .aluc(aluc8), .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .z(z8), .v(v8), .dz(dz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: result, flags and edges from accept until out_valid.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] op,
                                  output logic [31:0] ms, output logic mv, output logic mdz,
                                  output int medges);
        logic [31:0] bp;
        logic [63:0] p;
        int          sh;
        ms = 32'd0; mv = 1'b0; mdz = 1'b0; medges = 0;
        sh = int'(mb[4:0]);
        case (op)
            4'b0000, 4'b1000: begin
                bp = (op == 4'b1000) ? (32'd0 - mb) : mb;
                ms = ma + bp;
                mv = (ma[31] == bp[31]) && (ms[31] != ma[31]);
            end
            4'b0111: ms = ma & mb;
            4'b0110: ms = ma | mb;
            4'b0100: ms = ma ^ mb;
            4'b0010: ms = mb;
            4'b0001: ms = ma << sh;
            4'b0101: ms = ma >> sh;
            4'b1101: begin
                ms = ma >> sh;
                if (ma[31]) ms = ms | ~(32'hFFFF_FFFF >> sh);
            end
            4'b1111: ms = 32'($countones(ma ^ mb));
            4'b1001: begin
                p = {32'd0, ma} * {32'd0, mb};
                ms = p[31:0];
                medges = 32;
            end
            4'b1010, 4'b1110: begin
                if (mb == 32'd0) begin
                    ms  = (op == 4'b1010) ? 32'hFFFF_FFFF : ma;
                    mdz = 1'b1;
                end else begin
                    ms = (op == 4'b1010) ? (ma / mb) : (ma % mb);
                    medges = 32;
                end
            end
            default: ms = 32'd0;
        endcase
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b, input logic [3:0] op,
                          input int hold);
        logic [31:0] es;
        logic        ev, edz, saw_ready;
        int          eedges, edges;
        model(ta, tb_b, op, es, ev, edz, eedges);
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'(1));
        a = ta; b = tb_b; aluc = op; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // Keep offering garbage; it must be ignored while busy or done.
        a = $urandom; b = $urandom; aluc = 4'($urandom);
        edges = 0; saw_ready = 1'b0;
        while (!out_valid && edges < 100) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        check($sformatf("latency op%0h", op), 64'(edges), 64'(eedges));
        check($sformatf("busy_in_ready op%0h", op), 64'(saw_ready), 64'(0));
        check($sformatf("s op%0h a=%0h b=%0h", op, ta, tb_b), 64'(s), 64'(es));
        check($sformatf("z op%0h", op), 64'(z), 64'(es == 32'd0));
        check($sformatf("v op%0h", op), 64'(v), 64'(ev));
        check($sformatf("dz op%0h", op), 64'(dz), 64'(edz));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_s", 64'(s), 64'(es));
            check("hold_z", 64'(z), 64'(es == 32'd0));
            check("hold_v", 64'(v), 64'(ev));
            check("hold_out_valid", 64'(out_valid), 64'(1));
            check("hold_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_out_valid", 64'(out_valid), 64'(0));
        check("drain_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        int          e8;
        logic [31:0] rb;
        clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; aluc = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; aluc8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_s", 64'(s), 64'(0));
        check("rst_z", 64'(z), 64'(0));
        check("rst_v", 64'(v), 64'(0));
        check("rst_dz", 64'(dz), 64'(0));
        @(negedge clk);
        clrn = 1'b1;

        run_op(32'h7FFF_FFFF, 32'h1, 4'b0000, 0);
        run_op(32'd5, 32'd5, 4'b1000, 0);
        run_op(32'h8000_0000, 32'h36, 4'b1101, 0);
        run_op(32'hFF00_FF00, 32'h0F0F_0F0F, 4'b1111, 0);
        run_op(32'd1, 32'd2, 4'b0011, 0);
        run_op(32'd12345, 32'd6789, 4'b1001, 0);
        run_op(32'd100, 32'd7, 4'b1010, 0);
        run_op(32'd100, 32'd7, 4'b1110, 0);
        run_op(32'd9, 32'd0, 4'b1010, 0);
        run_op(32'd9, 32'd0, 4'b1110, 0);
        run_op(32'h8000_0000, 32'h1, 4'b1000, 5);

        // Reset in the middle of a multiply.
        @(negedge clk);
        a = 32'd12345; b = 32'd6789; aluc = 4'b1001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        clrn = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_s", 64'(s), 64'(0));
        @(negedge clk);
        clrn = 1'b1;
        run_op(32'd2, 32'd3, 4'b0000, 0);

        for (int n = 0; n < 60; n++) begin
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op($urandom, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        // Narrow instance: multiply latency tracks WIDTH, shamt uses 3 bits.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h11; aluc8 = 4'b1001; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        e8 = 0;
        while (!out_valid8 && e8 < 50) begin
            @(posedge clk); #1;
            e8++;
        end
        check("w8_mul_latency", 64'(e8), 64'(8));
        check("w8_mul_s", 64'(s8), 64'(8'h10));
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h0B; aluc8 = 4'b0001; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("w8_sll_valid", 64'(out_valid8), 64'(1));
        check("w8_sll_s", 64'(s8), 64'(8'h08));
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
